// File: rtl/rej_uniform_sampler.sv
// rej_uniform_sampler
// Kyber Parse / rejection sampler placed directly after the Keccak squeeze.
// It takes R-bit XOF rate blocks and turns each 3-byte triple into two 12-bit
// candidates. A candidate is accepted when it is below Q. The block emits N
// accepted coefficients, one per valid/ready handshake, and asks for another
// rate block each time the current one runs out.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   enable       in   start pulse, honoured only in IDLE or DONE
//   block_in     in   R-bit rate block, byte 0 = block_in[7:0] consumed first
//   block_valid  in   block_in valid
//   block_ready  out  sampler is waiting for a block (state == WAIT_BLK)
//   coeff        out  accepted coefficient, 0..Q-1
//   coeff_idx    out  index of coeff within the polynomial
//   coeff_valid  out  coeff/coeff_idx valid, held until coeff_ready
//   coeff_ready  in   downstream takes coeff this cycle
//   done         out  all N coefficients transferred
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for enable
// WAIT_BLK | block_ready high, waiting for a rate block
// PARSE    | test one candidate per cycle
// EMIT     | hold an accepted coefficient until coeff_ready
// DONE     | N coefficients transferred, done held until enable

module rej_uniform_sampler #(
    parameter int R = 1344,
    parameter int Q = 3329,
    parameter int N = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [R-1:0]  block_in,
    input  logic          block_valid,
    output logic          block_ready,
    output logic [11:0]   coeff,
    output logic [7:0]    coeff_idx,
    output logic          coeff_valid,
    input  logic          coeff_ready,
    output logic          done
);

    localparam int T  = R / 24;
    localparam int TW = (T > 1) ? $clog2(T) : 1;
    localparam logic [12:0] Q_LIM    = 13'(Q);
    localparam logic [TW-1:0] T_LAST = TW'(T - 1);
    localparam logic [7:0] CNT_LAST  = 8'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BLK,
        S_PARSE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // The block register shifts down one triple each time the pointer moves
    // on, so the current triple always sits in blk[23:0]. t is kept only to
    // detect the end of the block.
    logic [R-1:0]  blk;
    logic [TW-1:0] t;
    logic          h;
    logic [7:0]    count;

    logic [11:0] d1, d2, cand;
    logic        cand_ok, last;
    logic        start, latch, advance, load, xfer, finish;

    assign d1      = {blk[11:8], blk[7:0]};
    assign d2      = {blk[23:16], blk[15:12]};
    assign cand    = h ? d2 : d1;
    assign cand_ok = {1'b0, cand} < Q_LIM;
    assign last    = (t == T_LAST) && h;

    assign block_ready = (state == S_WAIT_BLK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        latch     = 1'b0;
        advance   = 1'b0;
        load      = 1'b0;
        xfer      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    start     = 1'b1;
                    state_nxt = S_WAIT_BLK;
                end
            end
            S_WAIT_BLK: begin
                if (block_valid) begin
                    latch     = 1'b1;
                    state_nxt = S_PARSE;
                end
            end
            S_PARSE: begin
                if (cand_ok) begin
                    // Pointer stays put until the coefficient is taken.
                    load      = 1'b1;
                    state_nxt = S_EMIT;
                end else begin
                    advance   = 1'b1;
                    state_nxt = last ? S_WAIT_BLK : S_PARSE;
                end
            end
            S_EMIT: begin
                if (coeff_ready) begin
                    xfer = 1'b1;
                    if (count == CNT_LAST) begin
                        finish    = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = last ? S_WAIT_BLK : S_PARSE;
                    end
                end
            end
            S_DONE: begin
                if (enable) begin
                    start     = 1'b1;
                    state_nxt = S_WAIT_BLK;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk         <= '0;
            t           <= '0;
            h           <= 1'b0;
            count       <= '0;
            coeff       <= '0;
            coeff_idx   <= '0;
            coeff_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (start) begin
                count <= '0;
                done  <= 1'b0;
            end
            if (latch) begin
                blk <= block_in;
                t   <= '0;
                h   <= 1'b0;
            end
            if (advance) begin
                if (!h) begin
                    h <= 1'b1;
                end else begin
                    h   <= 1'b0;
                    t   <= t + 1'b1;
                    blk <= blk >> 24;
                end
            end
            if (load) begin
                coeff       <= cand;
                coeff_idx   <= count;
                coeff_valid <= 1'b1;
            end
            if (xfer) begin
                coeff_valid <= 1'b0;
                count       <= count + 1'b1;
            end
            // coeff_valid drops on the same edge, so valid and done never overlap.
            if (finish) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rej_uniform_sampler.sv
module tb_rej_uniform_sampler;

    localparam int R = 1344;
    localparam int Q = 3329;
    localparam int N = 256;
    localparam int T = R / 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable = 1'b0;
    logic [R-1:0]  block_in = '0;
    logic          block_valid = 1'b0;
    logic          block_ready;
    logic [11:0]   coeff;
    logic [7:0]    coeff_idx;
    logic          coeff_valid;
    logic          coeff_ready = 1'b0;
    logic          done;

    rej_uniform_sampler #(.R(R), .Q(Q), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .block_in    (block_in),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .coeff       (coeff),
        .coeff_idx   (coeff_idx),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   mode_q[$];
    int   model_cnt = 0;
    int   blocks_run = 0;
    int   total = 0;
    int   bad = 0;
    int   drv_mode;
    bit   ready_force0 = 1'b0;
    bit   ready_always = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // mode 0 random, 1 all zero, 2 = 00 0D FF then FF, 3 = 01 0D 0D then random
    function automatic logic [R-1:0] make_block(input int mode);
        logic [R-1:0] b;
        for (int k = 0; k < R / 8; k++) b[8*k +: 8] = 8'($urandom);
        case (mode)
            1: b = '0;
            2: begin
                b = '1;
                b[7:0] = 8'h00; b[15:8] = 8'h0D; b[23:16] = 8'hFF;
            end
            3: begin
                b[7:0] = 8'h01; b[15:8] = 8'h0D; b[23:16] = 8'h0D;
            end
            default: ;
        endcase
        return b;
    endfunction

    // Reference Parse: walk the bytes with plain arithmetic.
    task automatic model_block(input logic [R-1:0] b);
        int b0, b1, b2, d1, d2;
        for (int i = 0; i < T; i++) begin
            b0 = int'(b[24*i +: 8]);
            b1 = int'(b[24*i+8 +: 8]);
            b2 = int'(b[24*i+16 +: 8]);
            d1 = b0 + 256 * (b1 % 16);
            d2 = b1 / 16 + 16 * b2;
            if (model_cnt < N && d1 < Q) begin
                exp_q.push_back('{d1, model_cnt});
                model_cnt++;
            end
            if (model_cnt < N && d2 < Q) begin
                exp_q.push_back('{d2, model_cnt});
                model_cnt++;
            end
        end
    endtask

    // Driver: block_valid toggles randomly in every state, so spurious
    // valids during PARSE/EMIT are exercised constantly.
    always @(posedge clk) begin
        #1;
        drv_mode = (mode_q.size() > 0) ? mode_q[0] : 0;
        block_valid = 1'($urandom_range(0, 1));
        if (block_valid) block_in = make_block(drv_mode);
        if (ready_force0) coeff_ready = 1'b0;
        else if (ready_always) coeff_ready = 1'b1;
        else coeff_ready = ($urandom_range(0, 9) < 7);
    end

    // Monitor / scoreboard
    exp_t e;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("valid_done_excl", {31'd0, coeff_valid & done}, 0);
            if (block_ready && block_valid) begin
                chk("block_req_before_full", {31'd0, model_cnt < N}, 1);
                blocks_run++;
                if (mode_q.size() > 0) void'(mode_q.pop_front());
                model_block(block_in);
            end
            if (coeff_valid && coeff_ready) begin
                chk("coeff_expected", {31'd0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("coeff_val", 32'(coeff), e.v);
                    chk("coeff_idx", 32'(coeff_idx), e.idx);
                end
            end
        end
    end

    task automatic pulse_enable_and_check();
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        chk("start_done_clear", {31'd0, done}, 0);
        chk("start_block_ready", {31'd0, block_ready}, 1);
    endtask

    task automatic do_run(input string tag, input bit mid_enable, input bit bp);
        int   cyc;
        bit   bp_done;
        logic [11:0] cap_c;
        logic [7:0]  cap_i;
        model_cnt  = 0;
        blocks_run = 0;
        bp_done    = 1'b0;
        pulse_enable_and_check();
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (mid_enable && cyc == 150) enable = 1'b1;
            if (mid_enable && cyc == 151) enable = 1'b0;
            if (bp && !bp_done && cyc > 60 && coeff_valid && !coeff_ready) begin
                ready_force0 = 1'b1;
                cap_c = coeff;
                cap_i = coeff_idx;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    cyc++;
                    chk("bp_valid_held", {31'd0, coeff_valid}, 1);
                    chk("bp_coeff_stable", 32'(coeff), 32'(cap_c));
                    chk("bp_idx_stable", 32'(coeff_idx), 32'(cap_i));
                end
                ready_force0 = 1'b0;
                bp_done = 1'b1;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 1);
        chk({tag, "_model_full"}, model_cnt, N);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        if (bp) chk({tag, "_bp_exercised"}, {31'd0, bp_done}, 1);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b0;
        #7;
        chk("rst_coeff", 32'(coeff), 0);
        chk("rst_idx", 32'(coeff_idx), 0);
        chk("rst_valid", {31'd0, coeff_valid}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_block_ready", {31'd0, block_ready}, 0);
        #5 rst = 1'b1;

        // All-zero blocks, ready always high: 112 + 112 + 32 coefficients.
        ready_always = 1'b1;
        mode_q = '{1, 1, 1, 1, 1};
        do_run("zero", 1'b0, 1'b0);
        chk("zero_blocks", blocks_run, 3);
        repeat (10) @(negedge clk);
        chk("zero_no_4th_block", blocks_run, 3);
        chk("zero_block_ready_low", {31'd0, block_ready}, 0);
        chk("zero_done_held", {31'd0, done}, 1);
        ready_always = 1'b0;

        // One coefficient 3328, then the rest of the block all rejected.
        mode_q = '{2, 1, 1, 1, 1};
        do_run("pat_3328", 1'b0, 1'b0);
        chk("pat_3328_blocks", blocks_run, 4);

        // d1 = 3329 rejected, d2 = 208 accepted.
        mode_q = '{3};
        do_run("pat_q_edge", 1'b0, 1'b0);

        // Random data with backpressure and a stray enable mid-run.
        mode_q.delete();
        do_run("rand_a", 1'b1, 1'b1);
        do_run("rand_b", 1'b0, 1'b1);
        do_run("rand_c", 1'b1, 1'b0);

        // Reset dropped while a coefficient is held in EMIT.
        begin
            int  cyc;
            bit  hit;
            model_cnt  = 0;
            pulse_enable_and_check();
            cyc = 0;
            hit = 1'b0;
            while (!hit && cyc < 2000) begin
                @(negedge clk);
                cyc++;
                if (coeff_valid && !coeff_ready) hit = 1'b1;
            end
            chk("mid_rst_emit_found", {31'd0, hit}, 1);
            ready_force0 = 1'b1;
            #2 rst = 1'b0;
            #1;
            chk("mid_rst_valid", {31'd0, coeff_valid}, 0);
            chk("mid_rst_block_ready", {31'd0, block_ready}, 0);
            chk("mid_rst_done", {31'd0, done}, 0);
            chk("mid_rst_idx", 32'(coeff_idx), 0);
            exp_q.delete();
            mode_q.delete();
            model_cnt = 0;
            @(negedge clk);
            ready_force0 = 1'b0;
            rst = 1'b1;
        end
        do_run("after_rst", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
